ahb_mem_slave: RTL
==================

# ahb_mem_slave

Parametrised AHB-Lite memory slave with configurable wait states, byte-lane writes and two-cycle ERROR responses. It is the next-generation slave model for the `ahb` subsystem and replaces pass-through stimulus slaves in bus-level simulation and on-chip scratch RAM. It decodes address and data phases itself and holds its own storage.

## Interface
Parameters:
- `DATA_W`, default `` `AHB_DATA_WIDTH `` (32 or 64): bus data width.
- `ADDR_W`, default `` `AHB_ADDR_WIDTH ``: bus address width.
- `DEPTH`, default 1024: storage size in `DATA_W` words.
- `WAIT_STATES`, default 0 (range 0–7): wait cycles inserted on every OKAY NONSEQ/SEQ transfer.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `hsel` in 1: slave select.
- `haddr_m2s` in `ADDR_W`: address; the offset inside the slave is the low bits.
- `htrans` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size, log2 of the byte count.
- `hdata_m2s` in `DATA_W`: write data, valid in the data phase.
- `hready_in` in 1: bus HREADY from the interconnect.
- `hready` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out `DATA_W`: read data.

## Operation
- **Address-phase accept:** an address phase is accepted when `hsel & htrans[1] & hready_in`. On accept, register address, `hwrite` and `hsize`.
  - IDLE/BUSY with `hsel`: zero-wait OKAY, no access.
  - `hsel` low: no access.
- **Error check at accept:** an accepted transfer is an error if any of these hold:
  - word index ≥ `DEPTH`;
  - address not aligned to `hsize`;
  - `hsize` > log2(`DATA_W`/8).
- **FSM states:**
  - IDLE → WAIT on a valid accept when `WAIT_STATES` > 0.
  - IDLE → DATA on a valid accept when `WAIT_STATES` = 0.
  - IDLE → ERR1 on an error accept.
  - WAIT counts down, then → DATA.
  - DATA is a one-cycle completion state. It returns to IDLE, or takes a new accept with the same transitions as from IDLE (back-to-back).
  - ERR1 → ERR2.
  - ERR2 → IDLE, or takes a new accept (bus pipelining).
- **Outputs per state:**
  - IDLE: `hready`=1, `hresp`=0.
  - WAIT: `hready`=0, `hresp`=0.
  - DATA: `hready`=1, `hresp`=0.
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
- **Writes:** memory is updated at the clock edge ending DATA. Byte enables come from `hsize` and the low address bits, little-endian lanes. Only enabled bytes of `hdata_m2s` are written. Errored writes never modify memory.
- **Reads:** in DATA, `hrdata` = the full stored word at the registered address; the master selects lanes. In all other states `hrdata` = 0.
- **Read after write:** a read immediately following a write to the same word returns the new data, because the write commits before the read's DATA cycle.
- **Reset values:** `hready`=1, `hresp`=0, `hrdata`=0, FSM IDLE, wait counter 0. Memory contents are not reset.
- **Reset mid-transfer:** asserting `rstn` mid-transfer aborts it. A write pending in WAIT is dropped; memory keeps its prior value.

## Timing
- **Latency:** (1 + `WAIT_STATES`) cycles from the address phase to the data-phase completion edge.
- **Errors:** always exactly 2 data-phase cycles regardless of `WAIT_STATES`.
- **Back-to-back:** with `WAIT_STATES`=0, one transfer completes per cycle.
- **Stalled address phase:** an address phase presented while `hready_in`=0 is ignored. The master must hold it; the slave re-samples it on the cycle where `hready_in`=1.

## Structure
- **Shared package `ahb_pkg`:**
  - `htrans_e` enum;
  - `hsize_e` enum;
  - `HRESP_OKAY` / `HRESP_ERROR` constants;
  - byte-enable function `ahb_strb(hsize, addr_lo)`.
- **Sub-module `ahb_mem_bank`:** `DEPTH`×`DATA_W` array with per-byte write enables and an asynchronous read port.
- **Top level:** FSM, wait counter, decode and error check live in `ahb_mem_slave`.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles, then release → `hready`=1, `hresp`=0, `hrdata`=0.
- **Word write/read, no waits:** `WAIT_STATES`=0. Write 0xDEADBEEF to 0x10, then immediately read 0x10 → OKAY, `hrdata`=0xDEADBEEF in the cycle after the read address phase.
- **Wait states:** `WAIT_STATES`=3. Read 0x10 → `hready` low for exactly 3 cycles, then high with data.
- **Byte write:** write byte 0xAA at 0x13 (`hsize`=0, `DATA_W`=32) over word 0x11223344 → read 0x10 returns 0xAA223344.
- **Error cases:** each returns ERR1 (`hready`=0, `hresp`=1), then ERR2 (`hready`=1, `hresp`=1), and memory is unchanged.
  - misaligned halfword at 0x11;
  - address `DEPTH`×4.
- **Reset mid-transfer:** `WAIT_STATES`=5. Assert `rstn` during WAIT of a write to 0x20 → outputs return to reset values; a subsequent read of 0x20 returns the old contents.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes and the byte-lane strobe helper
// used by the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Widest supported bus is 64 bits, so strobes are computed over 8 lanes
    localparam int STRB_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // Little-endian byte enables for a transfer of 2**hsize bytes at addr_lo
    function automatic logic [STRB_W-1:0] ahb_strb(input logic [2:0] hsize,
                                                   input logic [2:0] addr_lo);
        logic [15:0] span;
        span = (16'd1 << (8'd1 << hsize)) - 16'd1;
        return span[STRB_W-1:0] << addr_lo;
    endfunction

endpackage

// File: rtl/ahb_mem_bank.sv
// Word-addressed storage built from one byte-wide array per lane, giving
// per-byte write enables and an asynchronous read port. Contents are not reset.
module ahb_mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int LANES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [LANES-1:0]  wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && wstrb[l]) lane_mem[addr] <= wdata[8*l +: 8];
        end

        assign rdata[8*l +: 8] = lane_mem[addr];
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address-phase decode and error check, wait-state
// FSM with registered HREADY/HRESP, and a byte-lane memory bank.
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif

module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int DATA_W      = `AHB_DATA_WIDTH,
    parameter int ADDR_W      = `AHB_ADDR_WIDTH,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr_m2s,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [DATA_W-1:0] hdata_m2s,
    input  logic              hready_in,
    output logic              hready,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int LANES     = DATA_W / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int IDX_W     = $clog2(DEPTH);

    typedef struct packed {
        logic             write;
        logic [IDX_W-1:0] idx;
        logic [LANES-1:0] strb;
    } aph_t;

    slv_state_e        state;
    logic [2:0]        wcnt;
    aph_t              aph;

    htrans_e           trans;
    logic              accept;
    logic [ADDR_W-1:0] word_addr;
    logic [2:0]        addr_lo;
    logic [7:0]        lo_mask;
    logic              size_err, align_err, range_err, acc_err;
    logic [LANES-1:0]  acc_strb;
    logic [DATA_W-1:0] bank_rdata;

    // Address-phase decode
    assign trans     = htrans_e'(htrans);
    assign accept    = hsel && hready_in &&
                       (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
    assign word_addr = haddr_m2s >> LANE_BITS;
    assign addr_lo   = 3'(haddr_m2s[LANE_BITS-1:0]);
    assign lo_mask   = (8'd1 << hsize) - 8'd1;

    assign size_err  = hsize > 3'(LANE_BITS);
    assign align_err = |(8'(haddr_m2s[2:0]) & lo_mask);
    assign range_err = word_addr >= ADDR_W'(DEPTH);
    assign acc_err   = size_err || align_err || range_err;
    assign acc_strb  = LANES'(ahb_strb(hsize, addr_lo));

    // Accepts are only taken in states that drive hready high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            aph    <= '0;
            hready <= 1'b1;
            hresp  <= HRESP_OKAY;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wcnt == 3'd0) begin
                        state  <= ST_DATA;
                        hready <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state  <= ST_ERR2;
                    hready <= 1'b1;
                    hresp  <= HRESP_ERROR;
                end
                default: begin
                    if (accept) begin
                        aph <= '{write: hwrite,
                                 idx:   word_addr[IDX_W-1:0],
                                 strb:  acc_strb};
                        if (acc_err) begin
                            state  <= ST_ERR1;
                            hready <= 1'b0;
                            hresp  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state  <= ST_WAIT;
                            wcnt   <= 3'(WAIT_STATES - 1);
                            hready <= 1'b0;
                            hresp  <= HRESP_OKAY;
                        end else begin
                            state  <= ST_DATA;
                            hready <= 1'b1;
                            hresp  <= HRESP_OKAY;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        hready <= 1'b1;
                        hresp  <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Write commits on the edge ending DATA, so a following read sees it
    ahb_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (state == ST_DATA && aph.write),
        .addr  (aph.idx),
        .wstrb (aph.strb),
        .wdata (hdata_m2s),
        .rdata (bank_rdata)
    );

    assign hrdata = (state == ST_DATA) ? bank_rdata : '0;

endmodule
